// File: rtl/pes_stream_demux.sv
// Purpose: 1:N packet demultiplexer (unicast / broadcast / drop) with a one-entry register per channel.
// Latency: accepted beat appears on the target channel(s) exactly one cycle later; 1 beat/cycle per target.
// Backpressure: in_ready follows the target register(s) being free (pop+refill allowed); drop mode always ready.
module pes_stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic                    in_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic                    err_sel,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_BCAST = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  // Channel count in select width plus one bit, so the range compare needs no truncation.
  localparam logic [SEL_W:0] N_OUT_W = N_OUT[SEL_W:0];

  state_t            state_q;
  state_t            state_d;
  logic [SEL_W-1:0]  dest_q;
  logic [SEL_W-1:0]  dest_eff;
  logic              mode_bcast;
  logic              mode_drop;
  logic              sel_oob;
  logic              free_dest;
  logic              accept;
  logic [N_OUT-1:0]  chan_free;
  logic [N_OUT-1:0]  chan_wr;

  // A header select outside the implemented channel range sends the packet to the drop path.
  assign sel_oob = ({1'b0, in_sel} >= N_OUT_W);

  // A channel register can take a new beat when empty or being drained this cycle.
  assign chan_free = ~out_valid | out_ready;

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the header beat picks the mode, the last beat returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !in_last) begin
          if (in_bcast) begin
            state_d = S_BCAST;
          end else if (sel_oob) begin
            state_d = S_DROP;
          end else begin
            state_d = S_ROUTE;
          end
        end
      end
      default: begin
        if (accept && in_last) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Outputs of the FSM: effective destination/mode (live header fields in IDLE), in_ready and busy.
  always_comb begin
    dest_eff   = dest_q;
    mode_bcast = 1'b0;
    mode_drop  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        dest_eff   = in_sel;
        mode_bcast = in_bcast;
        mode_drop  = !in_bcast && sel_oob;
        busy       = 1'b0;
      end
      S_BCAST: mode_bcast = 1'b1;
      S_DROP:  mode_drop  = 1'b1;
      default: ;
    endcase

    free_dest = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (dest_eff == SEL_W'(k)) begin
        free_dest = chan_free[k];
      end
    end

    if (mode_drop) begin
      in_ready = 1'b1;
    end else if (mode_bcast) begin
      in_ready = &chan_free;
    end else begin
      in_ready = free_dest;
    end
  end

  // Per-channel write strobes for the accepted beat; nothing is written while dropping.
  always_comb begin
    chan_wr = '0;
    for (int k = 0; k < N_OUT; k++) begin
      chan_wr[k] = accept && !mode_drop && (mode_bcast || (dest_eff == SEL_W'(k)));
    end
  end

  // Latch the header destination so later beats ignore in_sel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dest_q <= '0;
    end else if (state_q == S_IDLE && accept) begin
      dest_q <= in_sel;
    end
  end

  // One pulse per dropped packet, on the cycle after its header is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= accept && (state_q == S_IDLE) && mode_drop;
    end
  end

  // Channel registers: load on write, clear to zero on pop, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_last  <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (chan_wr[k]) begin
          out_valid[k]                  <= 1'b1;
          out_last[k]                   <= in_last;
          out_data[k*DATA_W +: DATA_W]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k]                  <= 1'b0;
          out_last[k]                   <= 1'b0;
          out_data[k*DATA_W +: DATA_W]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pes_stream_demux.sv
module tb_pes_stream_demux;

  // Six channels so that selects 6 and 7 exercise the out-of-range drop path.
  localparam int DW    = 8;
  localparam int NO    = 6;
  localparam int SW    = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [SW-1:0]     in_sel;
  logic              in_bcast;
  logic              in_last;
  logic [NO-1:0]     out_valid;
  logic [NO-1:0]     out_ready;
  logic [NO*DW-1:0]  out_data;
  logic [NO-1:0]     out_last;
  logic              err_sel;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  pes_stream_demux #(.DATA_W(DW), .N_OUT(NO), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_sel   (err_sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return out_data[k*DW +: DW];
  endfunction

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat and let combinational in_ready settle.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic b, input logic l);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_last  = l;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = '1;
    drive(1'b1, 8'hFF, 3'd1, 1'b0, 1'b0);

    // Reset with in_valid high for two cycles.
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_last",  64'(out_last),  64'h0);
    chk("rst_err_sel",   64'(err_sel),   64'h0);
    chk("rst_busy",      64'(busy),      64'h0);
    rst_n = 1'b1;

    // Unicast 3-beat packet to channel 5; select changes mid-packet are ignored.
    drive(1'b1, 8'hA1, 3'd5, 1'b0, 1'b0);
    chk("uc_in_ready", 64'(in_ready), 64'h1);
    step();
    chk("uc_b1_valid", 64'(out_valid), 64'h20);
    chk("uc_b1_data",  64'(lane(5)),   64'hA1);
    chk("uc_b1_last",  64'(out_last),  64'h0);
    chk("uc_busy",     64'(busy),      64'h1);
    drive(1'b1, 8'hA2, 3'd2, 1'b0, 1'b0);
    step();
    chk("uc_b2_valid", 64'(out_valid), 64'h20);
    chk("uc_b2_data",  64'(lane(5)),   64'hA2);
    drive(1'b1, 8'hA3, 3'd2, 1'b0, 1'b1);
    step();
    chk("uc_b3_data",  64'(lane(5)),   64'hA3);
    chk("uc_b3_last",  64'(out_last),  64'h20);
    chk("uc_b3_busy",  64'(busy),      64'h0);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("uc_drain_valid", 64'(out_valid), 64'h0);
    chk("uc_drain_data",  64'(out_data),  64'h0);

    // Backpressure on channel 2 for four cycles.
    out_ready[2] = 1'b0;
    drive(1'b1, 8'hB1, 3'd2, 1'b0, 1'b0);
    chk("bp_hdr_ready", 64'(in_ready), 64'h1);
    step();
    drive(1'b1, 8'hB2, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_ready", 64'(in_ready),     64'h0);
      chk("bp_hold_data",   64'(lane(2)),      64'hB1);
      chk("bp_hold_valid",  64'(out_valid[2]), 64'h1);
      step();
    end
    chk("bp_hold_data4", 64'(lane(2)), 64'hB1);
    out_ready[2] = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_b2_data", 64'(lane(2)), 64'hB2);
    drive(1'b1, 8'hB3, 3'd0, 1'b0, 1'b1);
    chk("bp_b3_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_b3_data", 64'(lane(2)),  64'hB3);
    chk("bp_b3_last", 64'(out_last), 64'h04);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("bp_drain_valid", 64'(out_valid), 64'h0);

    // Broadcast while channel 3 is occupied and stalled.
    out_ready[3] = 1'b0;
    drive(1'b1, 8'h33, 3'd3, 1'b0, 1'b1);
    step();
    chk("bc_pre_data", 64'(lane(3)), 64'h33);
    drive(1'b1, 8'h55, 3'd0, 1'b1, 1'b0);
    chk("bc_stall_ready", 64'(in_ready), 64'h0);
    step();
    chk("bc_stall_ready2", 64'(in_ready),  64'h0);
    chk("bc_stall_valid",  64'(out_valid), 64'h08);
    out_ready[3] = 1'b1;
    #1;
    chk("bc_free_ready", 64'(in_ready), 64'h1);
    step();
    chk("bc_b1_valid", 64'(out_valid), 64'h3F);
    chk("bc_b1_data",  64'(out_data),  64'h555555555555);
    chk("bc_b1_last",  64'(out_last),  64'h0);
    drive(1'b1, 8'h66, 3'd1, 1'b0, 1'b1);
    chk("bc_b2_ready", 64'(in_ready), 64'h1);
    step();
    chk("bc_b2_data",  64'(out_data), 64'h666666666666);
    chk("bc_b2_last",  64'(out_last), 64'h3F);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("bc_drain_valid", 64'(out_valid), 64'h0);

    // Invalid select: 2-beat packet to channel 7, then a 1-beat packet to channel 6.
    drive(1'b1, 8'h77, 3'd7, 1'b0, 1'b0);
    chk("inv_hdr_ready", 64'(in_ready), 64'h1);
    step();
    chk("inv_err1",   64'(err_sel),   64'h1);
    chk("inv_valid1", 64'(out_valid), 64'h0);
    chk("inv_busy1",  64'(busy),      64'h1);
    drive(1'b1, 8'h78, 3'd1, 1'b0, 1'b1);
    chk("inv_b2_ready", 64'(in_ready), 64'h1);
    step();
    chk("inv_err2",   64'(err_sel),   64'h0);
    chk("inv_valid2", 64'(out_valid), 64'h0);
    chk("inv_busy2",  64'(busy),      64'h0);
    drive(1'b1, 8'h79, 3'd6, 1'b0, 1'b1);
    step();
    chk("inv1b_err",   64'(err_sel),   64'h1);
    chk("inv1b_valid", 64'(out_valid), 64'h0);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("inv1b_err_clr", 64'(err_sel), 64'h0);

    // Reset in the middle of a packet to channel 1.
    out_ready[1] = 1'b0;
    drive(1'b1, 8'hC1, 3'd1, 1'b0, 1'b0);
    step();
    chk("mr_b1_valid", 64'(out_valid), 64'h02);
    chk("mr_b1_busy",  64'(busy),      64'h1);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    chk("mr_rst_valid", 64'(out_valid), 64'h0);
    chk("mr_rst_busy",  64'(busy),      64'h0);
    rst_n     = 1'b1;
    out_ready = '1;
    drive(1'b1, 8'hC4, 3'd4, 1'b0, 1'b1);
    step();
    chk("mr_new_valid", 64'(out_valid), 64'h10);
    chk("mr_new_data",  64'(lane(4)),   64'hC4);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
